// File: rtl/sprite_compositor.sv
// Sprite compositor: rotated tank textures, square bullets, title/maze backdrops, hit-flash blinking.
// Three-stage pipeline (geometry+ROM address, ROM capture, priority/palette); RGB registered 3 cycles after the pixel.
module sprite_compositor #(
  parameter int NUM_TANKS    = 2,
  parameter int NUM_BULLETS  = 3,
  parameter int SPR_W        = 20,
  parameter int KEY_IDX      = 5,
  parameter int FLASH_FRAMES = 64
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       frame_start,
  input  logic                       blank,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic [1:0]                 mode,
  input  logic [10*NUM_TANKS-1:0]    tank_x,
  input  logic [10*NUM_TANKS-1:0]    tank_y,
  input  logic [8*NUM_TANKS-1:0]     tank_sin,
  input  logic [8*NUM_TANKS-1:0]     tank_cos,
  input  logic [NUM_TANKS-1:0]       tank_shot,
  input  logic [10*NUM_BULLETS-1:0]  bul_x,
  input  logic [10*NUM_BULLETS-1:0]  bul_y,
  input  logic [10*NUM_BULLETS-1:0]  bul_s,
  input  logic [NUM_BULLETS-1:0]     bul_active,
  output logic [9*NUM_TANKS-1:0]     tex_addr,
  input  logic [3*NUM_TANKS-1:0]     tex_idx,
  output logic [18:0]                title_addr,
  input  logic [2:0]                 title_idx,
  output logic [7:0]                 Red,
  output logic [7:0]                 Green,
  output logic [7:0]                 Blue
);

  localparam int NT   = NUM_TANKS;
  localparam int NB   = NUM_BULLETS;
  localparam int HALF = SPR_W / 2;
  // Counter must be at least 4 bits wide so the blink bit exists.
  localparam int CW   = ($clog2(FLASH_FRAMES + 1) < 4) ? 4 : $clog2(FLASH_FRAMES + 1);
  localparam logic signed [19:0] HALF_S = 20'(HALF);
  localparam logic signed [19:0] SPRW_S = 20'(SPR_W);
  localparam logic [2:0]         KEY    = 3'(KEY_IDX);

  function automatic logic [23:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFF3131;
      3'd1:    return 24'h312222;
      3'd2:    return 24'h878888;
      3'd3:    return 24'h9B9DAA;
      3'd4:    return 24'hFFEE00;
      3'd5:    return 24'hFF00D6;
      3'd6:    return 24'h000000;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic signed [19:0] ext11(input logic signed [10:0] a);
    return {{9{a[10]}}, a};
  endfunction

  function automatic logic signed [19:0] ext8(input logic [7:0] a);
    return {{12{a[7]}}, a};
  endfunction

  logic [9:0]    sh_tx  [NT];
  logic [9:0]    sh_ty  [NT];
  logic [7:0]    sh_sin [NT];
  logic [7:0]    sh_cos [NT];
  logic [9:0]    sh_bx  [NB];
  logic [9:0]    sh_by  [NB];
  logic [9:0]    sh_bs  [NB];
  logic [NB-1:0] sh_ba;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int t = 0; t < NT; t++) begin
        sh_tx[t]  <= '0;
        sh_ty[t]  <= '0;
        sh_sin[t] <= '0;
        sh_cos[t] <= '0;
      end
      for (int b = 0; b < NB; b++) begin
        sh_bx[b] <= '0;
        sh_by[b] <= '0;
        sh_bs[b] <= '0;
      end
      sh_ba <= '0;
    end else if (frame_start) begin
      for (int t = 0; t < NT; t++) begin
        sh_tx[t]  <= tank_x[t*10 +: 10];
        sh_ty[t]  <= tank_y[t*10 +: 10];
        sh_sin[t] <= tank_sin[t*8 +: 8];
        sh_cos[t] <= tank_cos[t*8 +: 8];
      end
      for (int b = 0; b < NB; b++) begin
        sh_bx[b] <= bul_x[b*10 +: 10];
        sh_by[b] <= bul_y[b*10 +: 10];
        sh_bs[b] <= bul_s[b*10 +: 10];
      end
      sh_ba <= bul_active;
    end
  end

  // A hit reloads the blink timer; running out of blink time kills the tank until reset.
  logic [CW-1:0] flash_cnt [NT];
  logic [NT-1:0] dead;
  logic [NT-1:0] vis;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int t = 0; t < NT; t++) flash_cnt[t] <= '0;
      dead <= '0;
    end else begin
      for (int t = 0; t < NT; t++) begin
        if (tank_shot[t]) begin
          flash_cnt[t] <= CW'(FLASH_FRAMES);
        end else if (frame_start && flash_cnt[t] != '0) begin
          flash_cnt[t] <= flash_cnt[t] - CW'(1);
          if (flash_cnt[t] == CW'(1)) dead[t] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    vis = '0;
    for (int t = 0; t < NT; t++)
      vis[t] = (flash_cnt[t] == '0) ? !dead[t] : flash_cnt[t][3];
  end

  logic [NT-1:0] tank_hit;

  for (genvar t = 0; t < NT; t++) begin : g_tank
    logic signed [10:0] dx, dy;
    logic signed [19:0] sum_x, sum_y, sx, sy;
    logic [8:0]         addr;
    logic               hit;

    always_comb begin
      dx    = $signed({1'b0, DrawX}) - $signed({1'b0, sh_tx[t]});
      dy    = $signed({1'b0, DrawY}) - $signed({1'b0, sh_ty[t]});
      sum_x = ext11(dx) * ext8(sh_cos[t]) + ext11(dy) * ext8(sh_sin[t]);
      sum_y = ext11(dy) * ext8(sh_cos[t]) - ext11(dx) * ext8(sh_sin[t]);
      sx    = sum_x >>> 6;
      sy    = sum_y >>> 6;
      hit   = (sx >= -HALF_S) && (sx < HALF_S) && (sy >= -HALF_S) && (sy < HALF_S);
      addr  = 9'((sy + HALF_S) * SPRW_S + (sx + HALF_S));
    end

    assign tank_hit[t]         = hit;
    assign tex_addr[t*9 +: 9]  = hit ? addr : 9'd0;
  end

  logic [NB-1:0] bul_hit;

  for (genvar b = 0; b < NB; b++) begin : g_bul
    logic signed [11:0] bdx, bdy;
    logic [11:0]        adx, ady;

    always_comb begin
      bdx = $signed({2'b00, DrawX}) - $signed({2'b00, sh_bx[b]});
      bdy = $signed({2'b00, DrawY}) - $signed({2'b00, sh_by[b]});
      adx = bdx[11] ? -bdx : bdx;
      ady = bdy[11] ? -bdy : bdy;
    end

    assign bul_hit[b] = sh_ba[b] && (adx <= {2'b00, sh_bs[b]}) && (ady <= {2'b00, sh_bs[b]});
  end

  assign title_addr = 19'(DrawY) * 19'd640 + 19'(DrawX);

  logic          s1_vld, s2_vld;
  logic [1:0]    s1_mode, s2_mode;
  logic [7:0]    s1_x, s1_y, s2_x, s2_y;
  logic          s1_bul, s2_bul;
  logic [NT-1:0] s1_tank, s2_tank;
  logic [3*NT-1:0] s2_tex;
  logic [2:0]    s2_title;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1_vld   <= 1'b0;
      s1_mode  <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_bul   <= 1'b0;
      s1_tank  <= '0;
      s2_vld   <= 1'b0;
      s2_mode  <= '0;
      s2_x     <= '0;
      s2_y     <= '0;
      s2_bul   <= 1'b0;
      s2_tank  <= '0;
      s2_tex   <= '0;
      s2_title <= '0;
    end else begin
      s1_vld   <= blank;
      s1_mode  <= mode;
      s1_x     <= DrawX[7:0];
      s1_y     <= DrawY[7:0];
      s1_bul   <= |bul_hit;
      s1_tank  <= tank_hit & vis;
      s2_vld   <= s1_vld;
      s2_mode  <= s1_mode;
      s2_x     <= s1_x;
      s2_y     <= s1_y;
      s2_bul   <= s1_bul;
      s2_tank  <= s1_tank;
      s2_tex   <= tex_idx;
      s2_title <= title_idx;
    end
  end

  logic [23:0] rgb;
  logic        found;

  always_comb begin
    rgb   = '0;
    found = 1'b0;
    if (s2_vld) begin
      case (s2_mode)
        2'd0: rgb = palette(s2_title);
        2'd1: rgb = {s2_x + s2_y, s2_x, s2_y};
        default: begin
          if (s2_bul) begin
            rgb = '0;
          end else begin
            rgb = 24'h555555;
            // Lowest index wins; key-coloured texels fall through to the next tank.
            for (int t = 0; t < NT; t++) begin
              if (!found && s2_tank[t] && s2_tex[t*3 +: 3] != KEY) begin
                rgb   = palette(s2_tex[t*3 +: 3]);
                found = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else begin
      Red   <= rgb[23:16];
      Green <= rgb[15:8];
      Blue  <= rgb[7:0];
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: behavioural ROMs, a reference pixel model and a latency-tagged RGB scoreboard.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, blank;
  logic [9:0]  DrawX, DrawY;
  logic [1:0]  mode;
  logic [19:0] tank_x, tank_y;
  logic [15:0] tank_sin, tank_cos;
  logic [1:0]  tank_shot;
  logic [29:0] bul_x, bul_y, bul_s;
  logic [2:0]  bul_active;
  logic [17:0] tex_addr;
  logic [5:0]  tex_idx;
  logic [18:0] title_addr;
  logic [2:0]  title_idx;
  logic [7:0]  Red, Green, Blue;

  always #5 clk = ~clk;

  sprite_compositor dut (
    .CLK(clk), .Reset(rst), .frame_start(frame_start), .blank(blank),
    .DrawX(DrawX), .DrawY(DrawY), .mode(mode),
    .tank_x(tank_x), .tank_y(tank_y), .tank_sin(tank_sin), .tank_cos(tank_cos),
    .tank_shot(tank_shot), .bul_x(bul_x), .bul_y(bul_y), .bul_s(bul_s),
    .bul_active(bul_active), .tex_addr(tex_addr), .tex_idx(tex_idx),
    .title_addr(title_addr), .title_idx(title_idx),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  logic [2:0] tex_mem [2][512];

  function automatic logic [2:0] title_fn(input logic [18:0] a);
    return a[2:0] ^ a[8:6];
  endfunction

  function automatic logic [23:0] pal(input logic [2:0] i);
    case (i)
      3'd0: return 24'hFF3131;
      3'd1: return 24'h312222;
      3'd2: return 24'h878888;
      3'd3: return 24'h9B9DAA;
      3'd4: return 24'hFFEE00;
      3'd5: return 24'hFF00D6;
      3'd6: return 24'h000000;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int t = 0; t < 2; t++) tex_idx[t*3 +: 3] <= tex_mem[t][tex_addr[t*9 +: 9]];
    title_idx <= title_fn(title_addr);
  end

  int m_tx[2], m_ty[2], m_sin[2], m_cos[2], m_cnt[2];
  bit m_dead[2];
  int m_bx[3], m_by[3], m_bs[3];
  bit m_ba[3];
  logic [1:0] cur_mode;

  function automatic bit model_tank(input int t, input int x, input int y, output int a);
    int dx, dy, sx, sy;
    dx = x - m_tx[t];
    dy = y - m_ty[t];
    sx = (dx * m_cos[t] + dy * m_sin[t]) >>> 6;
    sy = (dy * m_cos[t] - dx * m_sin[t]) >>> 6;
    a = 0;
    if (sx >= -10 && sx < 10 && sy >= -10 && sy < 10) begin
      a = (sy + 10) * 20 + sx + 10;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_vis(input int t);
    if (m_cnt[t] == 0) return !m_dead[t];
    return m_cnt[t][3];
  endfunction

  function automatic logic [23:0] model_rgb(input int x, input int y, input bit bl);
    int a;
    logic [18:0] ta;
    if (!bl) return 24'h0;
    if (cur_mode == 2'd0) begin
      ta = 19'(y * 640 + x);
      return pal(title_fn(ta));
    end
    if (cur_mode == 2'd1) return {8'(x + y), 8'(x), 8'(y)};
    for (int b = 0; b < 3; b++)
      if (m_ba[b] && x - m_bx[b] <= m_bs[b] && m_bx[b] - x <= m_bs[b] &&
          y - m_by[b] <= m_bs[b] && m_by[b] - y <= m_bs[b]) return 24'h0;
    for (int t = 0; t < 2; t++)
      if (model_vis(t) && model_tank(t, x, y, a) && tex_mem[t][a] != 3'd5) return pal(tex_mem[t][a]);
    return 24'h555555;
  endfunction

  typedef struct {
    int          due;
    logic [23:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];
  int  cyc = 0;
  int  errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      checks++;
      if ({Red, Green, Blue} !== e.exp) begin
        errors++;
        $display("FAIL %s: rgb got %06h expected %06h", e.name, {Red, Green, Blue}, e.exp);
      end
    end
  end

  task automatic pix(input int x, input int y, input bit bl, input string nm);
    sb_t e;
    @(negedge clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = bl;
    mode  = cur_mode;
    e.due  = cyc + 3;
    e.exp  = model_rgb(x, y, bl);
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic latch_model();
    for (int t = 0; t < 2; t++) begin
      m_tx[t]  = int'(tank_x[t*10 +: 10]);
      m_ty[t]  = int'(tank_y[t*10 +: 10]);
      m_sin[t] = $signed(tank_sin[t*8 +: 8]);
      m_cos[t] = $signed(tank_cos[t*8 +: 8]);
    end
    for (int b = 0; b < 3; b++) begin
      m_bx[b] = int'(bul_x[b*10 +: 10]);
      m_by[b] = int'(bul_y[b*10 +: 10]);
      m_bs[b] = int'(bul_s[b*10 +: 10]);
      m_ba[b] = bul_active[b];
    end
  endtask

  task automatic do_frame();
    @(negedge clk);
    frame_start = 1'b1;
    blank = 1'b0;
    latch_model();
    for (int t = 0; t < 2; t++)
      if (m_cnt[t] != 0) begin
        m_cnt[t]--;
        if (m_cnt[t] == 0) m_dead[t] = 1'b1;
      end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic shot(input int t, input bit with_frame);
    @(negedge clk);
    tank_shot[t] = 1'b1;
    if (with_frame) begin
      frame_start = 1'b1;
      blank = 1'b0;
      latch_model();
    end
    m_cnt[t] = 64;
    @(negedge clk);
    tank_shot   = '0;
    frame_start = 1'b0;
  endtask

  task automatic set_tank(input int t, input int x, input int y, input int s, input int c);
    tank_x[t*10 +: 10] = 10'(x);
    tank_y[t*10 +: 10] = 10'(y);
    tank_sin[t*8 +: 8] = 8'(s);
    tank_cos[t*8 +: 8] = 8'(c);
  endtask

  task automatic set_bul(input int b, input int x, input int y, input int s, input bit act);
    bul_x[b*10 +: 10] = 10'(x);
    bul_y[b*10 +: 10] = 10'(y);
    bul_s[b*10 +: 10] = 10'(s);
    bul_active[b]     = act;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_addr(input int t, input int exp, input string nm);
    #1;
    checks++;
    if (tex_addr[t*9 +: 9] !== 9'(exp)) begin
      errors++;
      $display("FAIL %s: tex_addr%0d got %0d expected %0d", nm, t, tex_addr[t*9 +: 9], exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    DrawX = 10'd3;
    DrawY = 10'd2;
    #1;
    checks++;
    if ({Red, Green, Blue} !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb: got %06h expected 000000", {Red, Green, Blue});
    end
    checks++;
    if (title_addr !== 19'd1283) begin
      errors++;
      $display("FAIL title_addr: got %0d expected 1283", title_addr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_geometry();
    pix(90, 90, 1, "corner_tl");    chk_addr(0, 0, "addr_tl");
    pix(109, 109, 1, "corner_br");  chk_addr(0, 399, "addr_br");
    pix(110, 100, 1, "right_out");  chk_addr(0, 0, "addr_right_out");
    pix(100, 89, 1, "top_out");     chk_addr(0, 0, "addr_top_out");
    pix(191, 191, 1, "tank1_tex");  chk_addr(1, 21, "addr_tank1");
    drain();
  endtask

  task automatic test_rotation();
    set_tank(0, 100, 100, 64, 0);
    do_frame();
    pix(100, 95, 1, "rot90");       chk_addr(0, 205, "addr_rot90");
    set_tank(0, 100, 100, 45, 45);
    do_frame();
    pix(103, 100, 1, "rot45");      chk_addr(0, 152, "addr_rot45");
    set_tank(0, 100, 100, 0, 64);
    do_frame();
    drain();
  endtask

  task automatic test_bullet();
    set_bul(0, 200, 200, 2, 1);
    set_bul(2, 1020, 0, 5, 1);
    do_frame();
    pix(201, 199, 1, "bullet_over_tank");
    pix(202, 202, 1, "bullet_corner");
    pix(203, 200, 1, "bullet_edge_out");
    pix(198, 197, 1, "bullet_y_out");
    pix(0, 0, 1, "bullet_no_wrap");
    set_bul(0, 200, 200, 2, 0);
    set_bul(2, 1020, 0, 5, 0);
    do_frame();
    pix(201, 199, 1, "bullet_inactive");
    drain();
  endtask

  task automatic test_transparency();
    set_tank(0, 200, 200, 0, 64);
    tex_mem[0][210] = 3'd5;
    tex_mem[1][210] = 3'd4;
    do_frame();
    pix(200, 200, 1, "key_shows_tank1");
    pix(300, 300, 1, "background");
    drain();
    tex_mem[0][210] = 3'd2;
    pix(200, 200, 1, "tank0_on_top");
    drain();
    tex_mem[1][210] = 3'd5;
    tex_mem[0][210] = 3'd5;
    pix(200, 200, 1, "both_keyed");
    drain();
    set_tank(0, 100, 100, 0, 64);
    do_frame();
  endtask

  task automatic test_mid_frame();
    set_tank(0, 150, 100, 0, 64);
    pix(109, 109, 1, "midframe_old_pos");  chk_addr(0, 399, "addr_midframe_old");
    pix(109, 109, 0, "blank_black");
    do_frame();
    pix(109, 109, 1, "newframe_old_pos");  chk_addr(0, 0, "addr_newframe_old");
    pix(159, 109, 1, "newframe_new_pos");  chk_addr(0, 399, "addr_newframe_new");
    set_tank(0, 100, 100, 0, 64);
    do_frame();
    drain();
  endtask

  task automatic test_modes();
    cur_mode = 2'd0;
    pix(5, 7, 1, "title_a");
    pix(639, 479, 1, "title_b");
    cur_mode = 2'd1;
    pix(300, 45, 1, "maze_a");
    pix(255, 1, 1, "maze_b");
    cur_mode = 2'd3;
    pix(109, 109, 1, "mode3_game");
    cur_mode = 2'd2;
    pix(101, 102, 1, "back_to_game");
    drain();
  endtask

  task automatic test_flash();
    tex_mem[1][315] = 3'd7;
    shot(1, 0);
    pix(205, 205, 1, "flash_start");
    for (int i = 0; i < 20; i++) begin
      do_frame();
      pix(205, 205, 1, "flash_blink");
    end
    shot(1, 1);
    pix(205, 205, 1, "flash_reload");
    for (int i = 0; i < 64; i++) begin
      do_frame();
      pix(205, 205, 1, "flash_blink2");
    end
    do_frame();
    pix(205, 205, 1, "dead_hidden");
    drain();
  endtask

  task automatic test_reset_midframe();
    tex_mem[0][210] = 3'd5;
    tex_mem[1][210] = 3'd7;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({Red, Green, Blue} !== 24'h0) begin
      errors++;
      $display("FAIL async_clear: got %06h expected 000000", {Red, Green, Blue});
    end
    for (int t = 0; t < 2; t++) begin
      m_tx[t] = 0; m_ty[t] = 0; m_sin[t] = 0; m_cos[t] = 0; m_cnt[t] = 0; m_dead[t] = 1'b0;
    end
    for (int b = 0; b < 3; b++) begin
      m_bx[b] = 0; m_by[b] = 0; m_bs[b] = 0; m_ba[b] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    begin
      sb_t e;
      e.due  = cyc + 3;
      e.exp  = model_rgb(205, 205, 1);
      e.name = "refill_first";
      sb.push_back(e);
    end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({Red, Green, Blue} !== 24'h0) begin
        errors++;
        $display("FAIL refill_black%0d: got %06h expected 000000", i, {Red, Green, Blue});
      end
    end
    drain();
    do_frame();
    pix(205, 205, 1, "revived_after_reset");
    drain();
  endtask

  initial begin
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 512; a++) tex_mem[t][a] = 3'((a * 3 + t) % 8);
    tex_mem[0][399] = 3'd6;
    tex_mem[1][191] = 3'd3;
    rst = 1'b1;
    frame_start = 1'b0;
    blank = 1'b0;
    DrawX = '0;
    DrawY = '0;
    cur_mode = 2'd2;
    mode = 2'd2;
    tank_shot = '0;
    for (int t = 0; t < 2; t++) begin
      m_cnt[t] = 0;
      m_dead[t] = 1'b0;
    end
    set_tank(0, 100, 100, 0, 64);
    set_tank(1, 200, 200, 0, 64);
    set_bul(0, 200, 200, 2, 0);
    set_bul(1, 500, 400, 1, 0);
    set_bul(2, 600, 50, 3, 0);

    test_reset();
    do_frame();
    test_geometry();
    test_rotation();
    test_bullet();
    test_transparency();
    test_mid_frame();
    test_modes();
    test_flash();
    test_reset_midframe();

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within 1 ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 SHALL have parameter NUM_TANKS, default 2, number of rotatable tank sprites.
REQ-002 SHALL have parameter NUM_BULLETS, default 3, number of square bullet sprites.
REQ-003 SHALL have parameter SPR_W, default 20, tank texture edge in pixels; HALF = SPR_W/2.
REQ-004 SHALL have parameter KEY_IDX, default 5, transparent palette index.
REQ-005 SHALL have parameter FLASH_FRAMES, default 64, hit-blink duration in frames.
REQ-006 SHALL have ports CLK in 1, pixel clock; Reset in 1, asynchronous active-high reset; one clock, all state on posedge CLK.
REQ-007 SHALL have ports frame_start in 1, one-cycle pulse at first blanked line; blank in 1, display enable (1 = visible); DrawX, DrawY in 10 each.
REQ-008 SHALL have ports mode in 2 (0 title, 1 maze, 2 game, 3 = game); tank_x, tank_y in 10*NUM_TANKS; tank_sin, tank_cos in 8*NUM_TANKS, signed Q1.6; tank_shot in NUM_TANKS, one-cycle hit pulses.
REQ-009 SHALL have ports bul_x, bul_y, bul_s in 10*NUM_BULLETS; bul_active in NUM_BULLETS.
REQ-010 SHALL have ports tex_addr out 9*NUM_TANKS; tex_idx in 3*NUM_TANKS; title_addr out 19; title_idx in 3. External ROMs return data exactly 1 cycle after the address.
REQ-011 SHALL have ports Red, Green, Blue out 8 each, registered.

Function
REQ-012 SHALL latch all tank/bullet inputs into shadow registers only on the CLK edge where frame_start=1; the pipeline uses shadow values only (no mid-frame tearing).
REQ-013 SHALL be a 3-stage pipeline: S0 geometry and ROM addresses, S1 ROM data capture, S2 priority/palette into output registers; RGB for (DrawX, DrawY) SHALL appear exactly 3 cycles after that pixel is presented, blank and mode delayed identically.
REQ-014 S0 per tank: dx = DrawX - tx, dy = DrawY - ty as signed 11-bit; sx = (dx*cos + dy*sin) >>> 6; sy = (dy*cos - dx*sin) >>> 6; products at least 19 bits signed, arithmetic shift.
REQ-015 Tank hit: -HALF <= sx < HALF and -HALF <= sy < HALF; u = sx + HALF, v = sy + HALF; tex_addr = v*SPR_W + u; tex_addr SHALL be 0 when not hit.
REQ-016 Bullet hit: bul_active and |DrawX - bx| <= s and |DrawY - by| <= s, signed compare, no 10-bit wrap.
REQ-017 title_addr = DrawY*640 + DrawX, driven in S0.
REQ-018 Palette: 0 FF3131, 1 312222, 2 878888, 3 9B9DAA, 4 FFEE00, 5 FF00D6, 6 000000, 7 FFFFFF.
REQ-019 S2 output select, first match wins: blank=0 -> 000000; mode 0 -> palette[title_idx]; mode 1 -> R = (DrawX+DrawY)[7:0], G = DrawX[7:0], B = DrawY[7:0]; game: lowest-index active bullet -> 000000; then lowest-index visible tank whose tex_idx != KEY_IDX -> palette[tex_idx]; else background 555555.
REQ-020 Per tank a flash counter: tank_shot loads FLASH_FRAMES; decrements by 1 on each frame_start while nonzero; tank visible while counter = 0 and not dead, or counter != 0 with (counter bit 3) = 1.
REQ-021 When a counter reaches 0 through decrement, the tank SHALL be marked dead (hidden) until Reset; tank_shot while counting SHALL reload FLASH_FRAMES; tank_shot and frame_start same cycle: reload wins.
REQ-022 Transparent texels (KEY_IDX) SHALL expose the next-priority tank, else background.

Reset
REQ-023 Reset SHALL asynchronously clear Red/Green/Blue to 0, all shadow registers to 0, pipeline valid/blank to 0, flash counters to 0, and dead flags to 0.
REQ-024 Reset mid-frame SHALL yield black output until the pipeline refills with blank=1 (3 cycles after release).

Verification
REQ-025 Tank 0 at (100,100), sin=0, cos=64, mode 2, pixel (90,90) -> tex_addr0 = 0; pixel (109,109) -> 399; RGB = palette[tex_idx0] 3 cycles later.
REQ-026 Tank 0 with sin=64, cos=0 (90 deg), pixel (100,95): dx=0, dy=-5 -> sx=-5, sy=0, tex_addr = 10*20+5 = 205.
REQ-027 Bullet 0 at (200,200) s=2 overlapping tank 1 -> pixel (201,199) is 000000; bullet inactive -> tank texel colour.
REQ-028 tex_idx returns 5 for tank 0 over tank 1 texel 4 -> FFEE00; no tank underneath -> 555555.
REQ-029 tank_shot[1] pulse, 64 frame_start pulses -> blinks on 8-frame cadence, then hidden permanently; Reset restores visible.
REQ-030 Change tank_x mid-frame -> rendered position unchanged until after next frame_start; blank=0 -> 000000 exactly 3 cycles later.
